rr_lock_arbiter: RTL and testbench
==================================

Name: rr_lock_arbiter

Overview:
Registered round-robin arbiter with grant locking, for sharing one resource (bus, memory port, datapath) among N requesters. A requester keeps its grant while it holds REQ high, up to a hold limit. It is pre-empted only if another requester is waiting. It sits in front of the shared resource and replaces fixed-priority granting so that no requester can be starved.

Parameters:
N, 4, number of requesters (2..16)
MAX_HOLD, 8, max consecutive cycles an owner keeps GNT while others wait (>=1)
IDW, $clog2(N), derived width of gnt_id
CW, $clog2(MAX_HOLD+1), derived width of hold counter

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  reset; synchronous and active-low: sampled only at posedge clk; reset==0 at an edge resets all state
REQ  input  N  request vector; bit i = requester i wants the resource
GNT  output  N  registered grant; one-hot or zero
gnt_id  output  IDW  index of current owner; 0 when no grant
gnt_valid  output  1  equals |GNT
preempt  output  1  one-cycle pulse: grant moved due to hold limit, not voluntary release

Behaviour:
- Reset (reset==0 at posedge clk): GNT=0, gnt_id=0, gnt_valid=0, preempt=0, pointer=0, hold count=0, state=IDLE. Reset dominates every other event.
- Pick function: first set bit of the candidate mask, searching pointer, pointer+1, ... N-1, 0, ... (mod N). Returns one-hot and index.
- States: IDLE (no owner), BUSY (owner o).
- IDLE:
  - REQ==0: stay in IDLE.
  - Else: at the edge, grant pick(REQ, pointer), count=1, go to BUSY.
  - Latency: REQ sampled at edge k gives GNT valid after edge k.
- BUSY, voluntary release (REQ[o]==0):
  - pointer=(o+1) mod N.
  - If other REQ bits are set: same edge, grant pick(REQ, (o+1) mod N), count=1. Direct handoff, no dead cycle.
  - Else: GNT=0, go to IDLE.
  - preempt=0.
- BUSY, preemption (REQ[o]==1, count==MAX_HOLD, REQ & ~onehot(o) != 0):
  - Grant pick(REQ & ~onehot(o), (o+1) mod N).
  - pointer=(o+1) mod N, count=1, preempt=1 for that cycle only.
- BUSY, continue (REQ[o]==1, no preemption):
  - GNT unchanged.
  - count increments, saturating at MAX_HOLD. A sole requester therefore keeps its grant indefinitely.
- preempt is 0 in every cycle not listed above.
- REQ is sampled only at edges. Mid-cycle changes are irrelevant.
- Invariants: GNT is one-hot or zero; gnt_id matches GNT; gnt_valid==|GNT.
- Fairness bound: a requester holding REQ high continuously is granted within (N-1)*MAX_HOLD+1 cycles.
- No combinational path from REQ to any output.

Decomposition:
- Package arb_pkg holds:
  - state enum (IDLE, BUSY)
  - default N / MAX_HOLD constants
  - onehot-to-index function
- Sub-module rr_pick: purely combinational. Inputs are mask[N] and ptr[IDW]; outputs are onehot[N], idx[IDW], any. Used for both the initial grant and handoff.
- FSM, pointer and counter live in rr_lock_arbiter.

Test Plan:
All scenarios use N=4, MAX_HOLD=4.
1. Reset: hold reset=0 with REQ=1111 for 2 edges -> GNT=0000, gnt_valid=0, preempt=0. Release reset -> first edge GNT=0001, gnt_id=0.
2. Full rotation: REQ=1111 held -> GNT=0001 for 4 cycles, then 0010, 0100, 1000 for 4 cycles each, then 0001. preempt=1 in the first cycle of each new grant.
3. Voluntary handoff: owner 1 (GNT=0010), REQ changes to 1001 -> next edge GNT=1000, gnt_id=3 (search starts at 2), preempt=0.
4. Sole requester: REQ=0100 for 10 cycles -> GNT=0100 throughout, preempt never asserted. Then REQ=0000 -> next edge GNT=0000, gnt_valid=0.
5. Wrap-around: owner 3 drops, REQ=0101 -> next edge GNT=0001. Owner 0 then drops -> GNT=0100.
6. Reset mid-operation: GNT=1000 with count=3, reset=0 for one edge -> GNT=0000, pointer=0. Reset released with REQ=1010 -> next edge GNT=0010.

Source files
------------

// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types, default sizing and helpers for the round-robin lock arbiter.
package arb_pkg;

  // Ownership state: IDLE has no owner, BUSY has exactly one granted requester.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_N        = 4;
  localparam int unsigned DEF_MAX_HOLD = 8;

  // Largest supported requester count; the index helper works on this width.
  localparam int unsigned MAX_N   = 16;
  localparam int unsigned MAX_IDW = 4;

  // Convert a one-hot (or zero) vector to its bit index; zero input yields 0.
  function automatic logic [MAX_IDW-1:0] onehot_to_index(input logic [MAX_N-1:0] oh);
    logic [MAX_IDW-1:0] idx;
    idx = {MAX_IDW{1'b0}};
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) begin
        idx = idx | MAX_IDW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_lock_arbiter_pick.sv
// Combinational round-robin picker: first set bit of mask at or after ptr, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N   = DEF_N,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [IDW:0]   sum_s;
  logic [IDW-1:0] pos_s;
  logic           found_s;

  // Walk the mask starting at ptr and latch the first requester found.
  always_comb begin
    onehot  = {N{1'b0}};
    idx     = {IDW{1'b0}};
    found_s = 1'b0;
    sum_s   = {(IDW+1){1'b0}};
    pos_s   = {IDW{1'b0}};
    for (int k = 0; k < N; k++) begin
      sum_s = {1'b0, ptr} + (IDW+1)'(k);
      if (sum_s >= (IDW+1)'(N)) begin
        sum_s = sum_s - (IDW+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      pos_s = sum_s[IDW-1:0];
      if (!found_s && mask[pos_s]) begin
        onehot[pos_s] = 1'b1;
        idx           = pos_s;
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    any = found_s;
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Registered round-robin arbiter with grant locking and a hold limit that
// only pre-empts the owner when someone else is waiting.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         REQ,
  output logic [N-1:0]         GNT,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 gnt_valid,
  output logic                 preempt
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned CW  = $clog2(MAX_HOLD + 1);

  arb_state_e     state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           valid_q, valid_d;
  logic           preempt_q, preempt_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [N-1:0]       pick_mask_s;
  logic [IDW-1:0]     pick_ptr_s;
  logic [N-1:0]       pick_oh_s;
  logic [IDW-1:0]     pick_idx_s;
  logic               pick_any_s;
  logic [IDW-1:0]     next_ptr_s;
  logic               owner_req_s;
  logic [MAX_N-1:0]   gnt_pad_s;
  logic [MAX_IDW-1:0] gnt_idx_s;

  // One picker serves both the idle grant and the busy handoff; excluding the
  // owner is harmless on voluntary release because its request is already low.
  always_comb begin
    if (state_q == BUSY) begin
      pick_mask_s = REQ & ~gnt_q;
      pick_ptr_s  = next_ptr_s;
    end else begin
      pick_mask_s = REQ;
      pick_ptr_s  = ptr_q;
    end
  end

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .mask   (pick_mask_s),
    .ptr    (pick_ptr_s),
    .onehot (pick_oh_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  // Search origin for the next owner: the slot just after the current owner.
  always_comb begin
    if (gnt_id_q == IDW'(N - 1)) begin
      next_ptr_s = {IDW{1'b0}};
    end else begin
      next_ptr_s = gnt_id_q + IDW'(1);
    end
    owner_req_s = |(REQ & gnt_q);
  end

  // Next-state logic for ownership, pointer, hold counter and pre-empt pulse.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|REQ) begin
          gnt_d   = pick_oh_s;
          cnt_d   = CW'(1);
          state_d = BUSY;
        end else begin
          gnt_d   = {N{1'b0}};
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!owner_req_s) begin
          // Voluntary release: hand off in the same edge if anyone waits.
          ptr_d = next_ptr_s;
          if (pick_any_s) begin
            gnt_d = pick_oh_s;
            cnt_d = CW'(1);
          end else begin
            gnt_d   = {N{1'b0}};
            cnt_d   = {CW{1'b0}};
            state_d = IDLE;
          end
        end else if ((cnt_q == CW'(MAX_HOLD)) && pick_any_s) begin
          // Hold limit reached with another requester waiting.
          gnt_d     = pick_oh_s;
          ptr_d     = next_ptr_s;
          cnt_d     = CW'(1);
          preempt_d = 1'b1;
        end else if (cnt_q == CW'(MAX_HOLD)) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = {N{1'b0}};
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Index and valid are derived from the next grant so all outputs stay registered.
  always_comb begin
    gnt_pad_s          = {MAX_N{1'b0}};
    gnt_pad_s[N-1:0]   = gnt_d;
    gnt_idx_s          = onehot_to_index(gnt_pad_s);
    gnt_id_d           = gnt_idx_s[IDW-1:0];
    valid_d            = |gnt_d;
  end

  // State registers with synchronous active-low reset dominating all updates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= {N{1'b0}};
      gnt_id_q  <= {IDW{1'b0}};
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      ptr_q     <= {IDW{1'b0}};
      cnt_q     <= {CW{1'b0}};
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign GNT       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed, table-driven bench for rr_lock_arbiter with N=4, MAX_HOLD=4.
module tb_rr_lock_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  int total;
  int bad;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       pre;
  } vec_t;

  vec_t vq[$];

  rr_lock_arbiter #(
    .N        (4),
    .MAX_HOLD (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .REQ       (req),
    .GNT       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  // Free-running clock, posedge at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add(input int n, input logic rst, input logic [3:0] r,
                     input logic [3:0] g, input logic [1:0] id, input logic p);
    for (int i = 0; i < n; i++) begin
      vq.push_back({rst, r, g, id, p});
    end
  endtask

  task automatic check(input string name, input logic [3:0] eg,
                       input logic [1:0] eid, input logic ep);
    logic ev;
    ev = |eg;
    total++;
    if (gnt !== eg || gnt_id !== eid || gnt_valid !== ev || preempt !== ep) begin
      bad++;
      $display("FAIL %s: got gnt=%b id=%0d valid=%b pre=%b, want gnt=%b id=%0d valid=%b pre=%b",
               name, gnt, gnt_id, gnt_valid, preempt, eg, eid, ev, ep);
    end
  endtask

  initial begin
    string nm;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    req   = 4'b1111;

    // reset held with all requesting
    add(2, 1'b0, 4'hF, 4'h0, 2'd0, 1'b0);
    // full rotation, MAX_HOLD=4 cycles each, preempt on each new owner
    add(4, 1'b1, 4'hF, 4'h1, 2'd0, 1'b0);
    add(1, 1'b1, 4'hF, 4'h2, 2'd1, 1'b1);
    add(3, 1'b1, 4'hF, 4'h2, 2'd1, 1'b0);
    add(1, 1'b1, 4'hF, 4'h4, 2'd2, 1'b1);
    add(3, 1'b1, 4'hF, 4'h4, 2'd2, 1'b0);
    add(1, 1'b1, 4'hF, 4'h8, 2'd3, 1'b1);
    add(3, 1'b1, 4'hF, 4'h8, 2'd3, 1'b0);
    add(1, 1'b1, 4'hF, 4'h1, 2'd0, 1'b1);
    add(3, 1'b1, 4'hF, 4'h1, 2'd0, 1'b0);
    add(1, 1'b1, 4'hF, 4'h2, 2'd1, 1'b1);
    // voluntary handoff from owner 1: search from 2 finds 3
    add(1, 1'b1, 4'h9, 4'h8, 2'd3, 1'b0);
    // sole requester 2 for 10 cycles, then release to idle
    add(10, 1'b1, 4'h4, 4'h4, 2'd2, 1'b0);
    add(1, 1'b1, 4'h0, 4'h0, 2'd0, 1'b0);
    // wrap-around: owner 3 drops with 0101 -> 0, then 0 drops -> 2
    add(1, 1'b1, 4'h8, 4'h8, 2'd3, 1'b0);
    add(1, 1'b1, 4'h5, 4'h1, 2'd0, 1'b0);
    add(1, 1'b1, 4'h4, 4'h4, 2'd2, 1'b0);
    // owner 3 to count 3, reset mid-operation, restart from pointer 0
    add(3, 1'b1, 4'h8, 4'h8, 2'd3, 1'b0);
    add(1, 1'b0, 4'h8, 4'h0, 2'd0, 1'b0);
    add(1, 1'b1, 4'hA, 4'h2, 2'd1, 1'b0);
    // preemption whose search wraps past N-1 back to 0
    add(3, 1'b1, 4'h3, 4'h2, 2'd1, 1'b0);
    add(1, 1'b1, 4'h3, 4'h1, 2'd0, 1'b1);
    add(1, 1'b1, 4'h3, 4'h1, 2'd0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst;
      req   = vq[i].req;
      @(posedge clk);
      #1;
      nm = $sformatf("vec%0d", i);
      check(nm, vq[i].gnt, vq[i].id, vq[i].pre);
    end

    // Mid-cycle REQ changes must not reach outputs nor the next decision.
    req = 4'b0000;
    #2;
    check("midcycle_hold", 4'h1, 2'd0, 1'b0);
    req = 4'b0011;
    @(posedge clk);
    #1;
    check("glitch_ignored", 4'h1, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    check("hold_cnt4", 4'h1, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    check("preempt_to_1", 4'h2, 2'd1, 1'b1);
    @(posedge clk);
    #1;
    check("preempt_pulse_clears", 4'h2, 2'd1, 1'b0);
    req = 4'b0000;
    @(posedge clk);
    #1;
    check("release_idle", 4'h0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    check("stay_idle", 4'h0, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
